// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks destination tags of in-flight instructions beyond EX,
// selects the bypass source for each EX operand and requests a stall on load-use.
module fwd_scoreboard #(
    parameter  int ADDR_W  = 5,
    parameter  int DEPTH   = 2,
    parameter  int NUM_SRC = 2,
    localparam int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        stall_i,
    input  logic                        flush_i,
    input  logic                        ex_regwrite_i,
    input  logic                        ex_memread_i,
    input  logic [ADDR_W-1:0]           ex_rd_i,
    input  logic [NUM_SRC*ADDR_W-1:0]   src_addr_i,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel_o,
    output logic                        hazard_o,
    output logic [15:0]                 hazard_cnt_o
);

    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   r_load;
    logic [ADDR_W-1:0]  r_rd [DEPTH];
    logic [15:0]        r_hazardCnt;

    logic [ADDR_W-1:0]  w_srcAddr [NUM_SRC];
    logic [SEL_W-1:0]   w_sel [NUM_SRC];
    logic [NUM_SRC-1:0] w_srcHazard;
    logic               w_hazard;
    logic               w_newValid;

    // Search from the oldest stage down so the youngest match overwrites older ones.
    // A load sitting in entry[0] cannot be bypassed yet; it raises the hazard instead.
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            w_srcAddr[s]   = src_addr_i[s*ADDR_W +: ADDR_W];
            w_sel[s]       = '0;
            w_srcHazard[s] = 1'b0;
            if (w_srcAddr[s] != '0) begin
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (r_valid[k] && (r_rd[k] == w_srcAddr[s]) && !((k == 0) && r_load[0])) begin
                        w_sel[s] = SEL_W'(k + 1);
                    end
                end
                if (r_valid[0] && r_load[0] && (r_rd[0] == w_srcAddr[s])) begin
                    w_srcHazard[s] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        fwd_sel_o = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            fwd_sel_o[s*SEL_W +: SEL_W] = w_sel[s];
        end
    end

    assign w_hazard     = |w_srcHazard;
    assign hazard_o     = w_hazard;
    assign hazard_cnt_o = r_hazardCnt;
    assign w_newValid   = ex_regwrite_i & ~flush_i & (ex_rd_i != '0);

    // Tag pipeline: stall freezes everything, a hazard injects a bubble into entry[0].
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid     <= '0;
            r_load      <= '0;
            r_hazardCnt <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_rd[k] <= '0;
            end
        end else if (!stall_i) begin
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_load[k]  <= r_load[k-1];
                r_rd[k]    <= r_rd[k-1];
            end
            if (w_hazard) begin
                r_valid[0] <= 1'b0;
                r_load[0]  <= 1'b0;
                r_rd[0]    <= '0;
                if (r_hazardCnt != 16'hFFFF) begin
                    r_hazardCnt <= r_hazardCnt + 16'd1;
                end
            end else begin
                r_valid[0] <= w_newValid;
                r_load[0]  <= ex_memread_i;
                r_rd[0]    <= ex_rd_i;
            end
        end
    end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: register-address width.
REQ-002 SHALL have parameter DEPTH, default 2, legal 1..7: number of tracked in-flight stages beyond EX.
REQ-003 SHALL have parameter NUM_SRC, default 2: number of EX source operands checked.
REQ-004 SHALL derive SEL_W = clog2(DEPTH+1) locally; not overridable.
REQ-005 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i  input  1  reset; asynchronous and active-high.
REQ-007 SHALL have port stall_i  input  1  external pipeline freeze; holds all state.
REQ-008 SHALL have port flush_i  input  1  kill the instruction currently in EX.
REQ-009 SHALL have port ex_regwrite_i  input  1  EX instruction writes a register.
REQ-010 SHALL have port ex_memread_i  input  1  EX instruction is a load.
REQ-011 SHALL have port ex_rd_i  input  ADDR_W  EX destination register.
REQ-012 SHALL have port src_addr_i  input  NUM_SRC*ADDR_W  EX source registers; source s in bits [s*ADDR_W +: ADDR_W].
REQ-013 SHALL have port fwd_sel_o  output  NUM_SRC*SEL_W  per-source bypass select, same packing as src_addr_i.
REQ-014 SHALL have port hazard_o  output  1  load-use stall request.
REQ-015 SHALL have port hazard_cnt_o  output  16  saturating count of hazard cycles.

Function
REQ-016 SHALL hold a tag pipeline entry[0..DEPTH-1], each {valid, load, rd}; entry[0] is the youngest (EX/MEM position).
REQ-017 SHALL, on a rising edge with stall_i=0 and hazard_o=0, load entry[0] <= {ex_regwrite_i & ~flush_i & (ex_rd_i!=0), ex_memread_i, ex_rd_i}, and shift entry[k] <= entry[k-1] for k>=1.
REQ-018 SHALL, on an edge with stall_i=0 and hazard_o=1, shift entry[k] <= entry[k-1] for k>=1 and load entry[0] with a bubble (valid=0), ignoring the ex_* inputs.
REQ-019 SHALL, on an edge with stall_i=1, hold all entries and hazard_cnt_o unchanged; stall_i has priority over hazard_o and flush_i.
REQ-020 SHALL compute fwd_sel_o combinationally: for source s, select k+1 for the smallest k with entry[k].valid and entry[k].rd == src_s, and 0 (register file) when no entry matches or src_s == 0.
REQ-021 SHALL exclude entry[0] from matching when entry[0].load=1; such a match instead contributes to hazard_o, and the search continues from entry[1].
REQ-022 SHALL assert hazard_o combinationally when any source s has src_s != 0 and entry[0] is valid, is a load and has rd == src_s.
REQ-023 SHALL select the youngest matching stage when several stages hold the same rd.
REQ-024 SHALL never match register 0; a write to rd=0 SHALL be recorded with valid=0.
REQ-025 SHALL increment hazard_cnt_o on each edge with hazard_o=1 and stall_i=0, saturating at 16'hFFFF without wrap.
REQ-026 SHALL produce zero-latency outputs: fwd_sel_o and hazard_o depend only on current state and src_addr_i.

Reset
REQ-027 SHALL, while rst_i=1, asynchronously clear every entry (valid=0, load=0, rd=0) and set hazard_cnt_o=0, giving fwd_sel_o=0 and hazard_o=0.
REQ-028 SHALL, on rst_i asserting mid-operation, discard all in-flight tags; the first edge after release behaves as REQ-017 from an empty pipeline.

Verification (defaults ADDR_W=5, DEPTH=2, NUM_SRC=2)
REQ-029 SHALL cover: issue regwrite rd=3, then src={3,0} -> fwd_sel=2'b01 for src0 next cycle, 2'b10 one cycle later, 0 after that.
REQ-030 SHALL cover: consecutive writes rd=4 then rd=4, src0=4 -> select 1 (youngest), never 2.
REQ-031 SHALL cover: load rd=5, then src1=5 -> hazard_o=1 for exactly one cycle, entry[0] becomes a bubble, then fwd_sel src1=2, hazard_cnt_o=1.
REQ-032 SHALL cover: write rd=0 and src=0 -> fwd_sel=0, hazard_o=0; flush_i=1 with rd=6 -> no later match on 6.
REQ-033 SHALL cover: stall_i=1 for 3 cycles with rd=7 in entry[0] -> select stays 1, hazard_cnt_o unchanged; with hazard_cnt_o preloaded to 16'hFFFF -> it holds at 16'hFFFF on further hazards.
REQ-034 SHALL cover: rst_i pulsed between clock edges while entries are valid -> outputs go to 0 immediately, without waiting for a clock edge.
